// File: rtl/mlow_codec_scheduler.sv
// Arbitrates the shared MLow codec core between encode (audio frames) and
// decode (received packets): round-robin grant, start pulse, watchdog supervision.

module mlow_frame_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  cnt <= '0;
    else if (inc)    cnt <= cnt + 1'b1;
  end

endmodule

module mlow_codec_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_W          = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enc_en_i,
  input  logic             dec_en_i,
  input  logic [3:0]       bitrate_sel_i,
  input  logic [1:0]       bandwidth_sel_i,
  input  logic             frame_bus_valid_i,
  output logic             frame_bus_ready_o,
  input  logic             pkt_rx_valid_i,
  output logic             pkt_rx_ready_o,
  output logic             core_start_o,
  output logic             core_op_o,
  output logic             core_abort_o,
  input  logic             core_done_i,
  input  logic             core_error_i,
  output logic [3:0]       cfg_bitrate_o,
  output logic [1:0]       cfg_bandwidth_o,
  input  logic             err_clr_i,
  output logic             busy_o,
  output logic             error_o,
  output logic [CNT_W-1:0] enc_frames_o,
  output logic [CNT_W-1:0] dec_frames_o,
  output logic [7:0]       timeout_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [TMO_W-1:0] WDOG_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic             last_op;
  logic [TMO_W-1:0] wdog;
  logic             req_e, req_d, gnt_e, gnt_d;
  logic             in_idle, in_wait, done_ok, tmo_hit, err_set;

  assign in_idle = (state == S_IDLE);
  assign in_wait = (state == S_WAIT);

  // On a tie the side opposite the last granted op wins; last_op resets to decode.
  assign req_e = frame_bus_valid_i & enc_en_i;
  assign req_d = pkt_rx_valid_i & dec_en_i;
  assign gnt_e = req_e & (~req_d | ~last_op);
  assign gnt_d = req_d & (~req_e |  last_op);

  assign frame_bus_ready_o = in_idle & gnt_e;
  assign pkt_rx_ready_o    = in_idle & gnt_d;

  // Done in the last watchdog cycle takes priority over the abort.
  assign done_ok = in_wait & core_done_i;
  assign tmo_hit = in_wait & ~core_done_i & (wdog == '0);
  assign err_set = (done_ok & core_error_i) | tmo_hit;

  assign core_start_o = (state == S_START);
  assign core_abort_o = tmo_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_e | gnt_d)      state_nxt = S_START;
      S_START:                         state_nxt = S_WAIT;
      S_WAIT:  if (done_ok | tmo_hit)  state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= S_IDLE;
      busy_o          <= 1'b0;
      core_op_o       <= 1'b0;
      last_op         <= 1'b0;
      cfg_bitrate_o   <= 4'h0;
      cfg_bandwidth_o <= 2'b00;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != S_IDLE);
      if (in_idle && (gnt_e || gnt_d)) begin
        core_op_o       <= gnt_e;
        last_op         <= gnt_e;
        cfg_bitrate_o   <= bitrate_sel_i;
        cfg_bandwidth_o <= bandwidth_sel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                   wdog <= '0;
    else if (state == S_START)        wdog <= WDOG_LOAD;
    else if (in_wait && wdog != '0)   wdog <= wdog - 1'b1;
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)      error_o <= 1'b0;
    else if (err_set)    error_o <= 1'b1;
    else if (err_clr_i)  error_o <= 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                             timeout_cnt_o <= 8'h00;
    else if (tmo_hit && timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'h01;
  end

  // Index 1 counts encodes, index 0 decodes.
  logic [1:0][CNT_W-1:0] frame_cnt;
  logic [1:0]            frame_inc;

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    assign frame_inc[g] = done_ok & ((g == 1) ? core_op_o : ~core_op_o);
    mlow_frame_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc       (frame_inc[g]),
      .cnt       (frame_cnt[g])
    );
  end

  assign enc_frames_o = frame_cnt[1];
  assign dec_frames_o = frame_cnt[0];

endmodule

// File: tb/tb_mlow_codec_scheduler.sv
// Self-checking bench for mlow_codec_scheduler: directed table, corner sequences,
// and random traffic against a transaction-level reference model.

module tb_mlow_codec_scheduler;

  localparam int TMO = 8;
  localparam int CW  = 16;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          enc_en_i, dec_en_i;
  logic [3:0]    bitrate_sel_i;
  logic [1:0]    bandwidth_sel_i;
  logic          frame_bus_valid_i, pkt_rx_valid_i;
  logic          frame_bus_ready_o, pkt_rx_ready_o;
  logic          core_start_o, core_op_o, core_abort_o;
  logic          core_done_i, core_error_i, err_clr_i;
  logic [3:0]    cfg_bitrate_o;
  logic [1:0]    cfg_bandwidth_o;
  logic          busy_o, error_o;
  logic [CW-1:0] enc_frames_o, dec_frames_o;
  logic [7:0]    timeout_cnt_o;

  always #5 clk_i = ~clk_i;

  mlow_codec_scheduler #(.TIMEOUT_CYCLES(TMO), .TMO_W(16), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .enc_en_i(enc_en_i), .dec_en_i(dec_en_i),
    .bitrate_sel_i(bitrate_sel_i), .bandwidth_sel_i(bandwidth_sel_i),
    .frame_bus_valid_i(frame_bus_valid_i), .frame_bus_ready_o(frame_bus_ready_o),
    .pkt_rx_valid_i(pkt_rx_valid_i), .pkt_rx_ready_o(pkt_rx_ready_o),
    .core_start_o(core_start_o), .core_op_o(core_op_o), .core_abort_o(core_abort_o),
    .core_done_i(core_done_i), .core_error_i(core_error_i),
    .cfg_bitrate_o(cfg_bitrate_o), .cfg_bandwidth_o(cfg_bandwidth_o),
    .err_clr_i(err_clr_i), .busy_o(busy_o), .error_o(error_o),
    .enc_frames_o(enc_frames_o), .dec_frames_o(dec_frames_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation in flight is tracked by its age in cycles since
  // grant (age 1 = start cycle); it times out TMO cycles after the start cycle.
  bit       m_busy, m_op, m_last, m_err;
  int       m_age, m_enc, m_dec, m_tmo;
  bit [3:0] m_br;
  bit [1:0] m_bw;

  task automatic model_reset();
    m_busy = 0; m_op = 0; m_last = 0; m_err = 0;
    m_age = 0; m_enc = 0; m_dec = 0; m_tmo = 0;
    m_br = 0; m_bw = 0;
  endtask

  task automatic clear_inputs();
    enc_en_i = 0; dec_en_i = 0; bitrate_sel_i = 0; bandwidth_sel_i = 0;
    frame_bus_valid_i = 0; pkt_rx_valid_i = 0;
    core_done_i = 0; core_error_i = 0; err_clr_i = 0;
  endtask

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic tick();
    bit re, rd, pe, pd, e_start, e_abort, set;
    re = frame_bus_valid_i & enc_en_i;
    rd = pkt_rx_valid_i & dec_en_i;
    pe = 0; pd = 0;
    if (!m_busy) begin
      if (re && rd) begin pe = !m_last; pd = m_last; end
      else begin pe = re; pd = rd; end
    end
    e_start = m_busy && (m_age == 1);
    e_abort = m_busy && (m_age == TMO + 1) && !core_done_i;
    #1;
    chk("frame_ready", frame_bus_ready_o, pe);
    chk("pkt_ready",   pkt_rx_ready_o,    pd);
    chk("start",       core_start_o,      e_start);
    chk("abort",       core_abort_o,      e_abort);
    chk("core_op",     core_op_o,         m_op);
    chk("cfg_bitrate", cfg_bitrate_o,     m_br);
    chk("cfg_bw",      cfg_bandwidth_o,   m_bw);
    chk("busy",        busy_o,            m_busy);
    chk("error",       error_o,           m_err);
    chk("enc_frames",  enc_frames_o,      m_enc & 32'hFFFF);
    chk("dec_frames",  dec_frames_o,      m_dec & 32'hFFFF);
    chk("timeouts",    timeout_cnt_o,     m_tmo);
    @(posedge clk_i);
    set = 0;
    if (!m_busy) begin
      if (pe || pd) begin
        m_busy = 1; m_age = 1; m_op = pe; m_last = pe;
        m_br = bitrate_sel_i; m_bw = bandwidth_sel_i;
      end
    end else if (m_age >= 2 && core_done_i) begin
      if (m_op) m_enc++; else m_dec++;
      if (core_error_i) set = 1;
      m_busy = 0;
    end else if (m_age == TMO + 1) begin
      set = 1;
      if (m_tmo < 255) m_tmo++;
      m_busy = 0;
    end else begin
      m_age++;
    end
    m_err = set ? 1'b1 : (err_clr_i ? 1'b0 : m_err);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1;
    model_reset();
  endtask

  typedef struct {
    bit fv, pv, ee, ed, dn, ce, clr;
    bit frdy, prdy, st, op, busy, err;
    int enc, dec;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // fv pv ee ed dn ce clr | frdy prdy st op busy err enc dec
    tbl[0]  = '{1,0,1,0,0,0,0, 1,0,0,0,0,0, 0,0};
    tbl[1]  = '{0,0,1,0,0,0,0, 0,0,1,1,1,0, 0,0};
    tbl[2]  = '{0,0,1,0,0,0,0, 0,0,0,1,1,0, 0,0};
    tbl[3]  = '{0,0,1,0,0,0,0, 0,0,0,1,1,0, 0,0};
    tbl[4]  = '{0,0,1,0,0,0,0, 0,0,0,1,1,0, 0,0};
    tbl[5]  = '{0,0,1,0,1,0,0, 0,0,0,1,1,0, 0,0};
    tbl[6]  = '{0,1,0,1,0,0,0, 0,1,0,1,0,0, 1,0};
    tbl[7]  = '{0,0,0,1,0,0,0, 0,0,1,0,1,0, 1,0};
    tbl[8]  = '{0,0,0,1,1,1,1, 0,0,0,0,1,0, 1,0};
    tbl[9]  = '{0,0,0,1,0,0,0, 0,0,0,0,0,1, 1,1};
    tbl[10] = '{0,0,0,1,0,0,1, 0,0,0,0,0,1, 1,1};
    tbl[11] = '{0,0,0,1,0,0,0, 0,0,0,0,0,0, 1,1};

    clear_inputs();
    reset_n_i = 0;
    repeat (3) @(negedge clk_i);
    reset_n_i = 1;
    model_reset();
    tick();  // reset values

    // Directed table: single encode, then decode with error set/clear collision
    for (int i = 0; i < 12; i++) begin
      frame_bus_valid_i = tbl[i].fv; pkt_rx_valid_i = tbl[i].pv;
      enc_en_i = tbl[i].ee; dec_en_i = tbl[i].ed;
      core_done_i = tbl[i].dn; core_error_i = tbl[i].ce; err_clr_i = tbl[i].clr;
      #1;
      chk("tbl_frdy", frame_bus_ready_o, tbl[i].frdy);
      chk("tbl_prdy", pkt_rx_ready_o,    tbl[i].prdy);
      chk("tbl_start", core_start_o,     tbl[i].st);
      chk("tbl_op",   core_op_o,         tbl[i].op);
      chk("tbl_busy", busy_o,            tbl[i].busy);
      chk("tbl_err",  error_o,           tbl[i].err);
      chk("tbl_enc",  enc_frames_o,      tbl[i].enc);
      chk("tbl_dec",  dec_frames_o,      tbl[i].dec);
      tick();
    end

    // Tie arbitration: alternating E,D,E,D starting with encode
    do_reset();
    frame_bus_valid_i = 1; pkt_rx_valid_i = 1; enc_en_i = 1; dec_en_i = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_start", core_start_o, 1);
      chk("tie_op", core_op_o, (k % 2 == 0) ? 1 : 0);
      tick();
      tick();
      core_done_i = 1;
      tick();
      core_done_i = 0;
    end
    chk("tie_enc", enc_frames_o, 2);
    chk("tie_dec", dec_frames_o, 2);

    // Timeout: abort 8 cycles after start
    do_reset();
    enc_en_i = 1; frame_bus_valid_i = 1;
    tick();
    frame_bus_valid_i = 0;
    tick();
    repeat (TMO - 1) tick();
    #1;
    chk("tmo_abort", core_abort_o, 1);
    tick();
    chk("tmo_error", error_o, 1);
    chk("tmo_cnt", timeout_cnt_o, 1);
    chk("tmo_enc", enc_frames_o, 0);

    // Timeout counter saturation
    for (int k = 0; k < 260; k++) begin
      frame_bus_valid_i = 1;
      tick();
      frame_bus_valid_i = 0;
      repeat (TMO + 1) tick();
    end
    chk("tmo_sat", timeout_cnt_o, 255);

    // Done on the abort cycle: done wins
    do_reset();
    enc_en_i = 1; frame_bus_valid_i = 1;
    tick();
    frame_bus_valid_i = 0;
    tick();
    repeat (TMO - 1) tick();
    core_done_i = 1;
    #1;
    chk("col_abort", core_abort_o, 0);
    tick();
    core_done_i = 0;
    chk("col_tmo", timeout_cnt_o, 0);
    chk("col_enc", enc_frames_o, 1);
    chk("col_err", error_o, 0);

    // Config latched at grant only
    do_reset();
    enc_en_i = 1; bitrate_sel_i = 5; bandwidth_sel_i = 2; frame_bus_valid_i = 1;
    tick();
    frame_bus_valid_i = 0; bitrate_sel_i = 9; bandwidth_sel_i = 1;
    tick();
    tick();
    chk("cfg_hold_br", cfg_bitrate_o, 5);
    chk("cfg_hold_bw", cfg_bandwidth_o, 2);
    core_done_i = 1;
    tick();
    core_done_i = 0;
    chk("cfg_idle_br", cfg_bitrate_o, 5);
    frame_bus_valid_i = 1;
    tick();
    chk("cfg_new_br", cfg_bitrate_o, 9);
    chk("cfg_new_bw", cfg_bandwidth_o, 1);

    // Reset mid-WAIT: asynchronous return, no abort
    do_reset();
    enc_en_i = 1; bitrate_sel_i = 7; frame_bus_valid_i = 1;
    tick();
    frame_bus_valid_i = 0;
    tick();
    tick();
    reset_n_i = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_start", core_start_o, 0);
    chk("rst_abort", core_abort_o, 0);
    chk("rst_op", core_op_o, 0);
    chk("rst_cfg", cfg_bitrate_o, 0);
    chk("rst_enc", enc_frames_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    chk("rst_abort_edge", core_abort_o, 0);
    @(negedge clk_i);
    reset_n_i = 1;
    frame_bus_valid_i = 1;
    tick();
    chk("rst_regrant", core_start_o, 1);
    frame_bus_valid_i = 0;

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      frame_bus_valid_i = 1'($urandom_range(0, 1));
      pkt_rx_valid_i    = 1'($urandom_range(0, 1));
      enc_en_i          = ($urandom_range(0, 7) != 0);
      dec_en_i          = ($urandom_range(0, 7) != 0);
      core_done_i       = ($urandom_range(0, 5) == 0);
      core_error_i      = ($urandom_range(0, 3) == 0);
      err_clr_i         = ($urandom_range(0, 7) == 0);
      bitrate_sel_i     = 4'($urandom_range(0, 15));
      bandwidth_sel_i   = 2'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
